// File: rtl/prbs_sym_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prbs_sym_checker                                              |
// | Purpose  : Receive-side PRBS symbol checker. Slices strobed signed I/Q   |
// |            samples (BPSK/QPSK/4-level/8-level per axis) to bits, sends   |
// |            them out oldest-first, self-synchronises a PRBS reference and |
// |            reports lock, compared-bit count and bit-error count.         |
// | Options  : define ERR_INJECT_EN to add the 'inj' input, which inverts    |
// |            the next compared received bit.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module prbs_sym_checker #(
    parameter int LOCK_CNT = 32,
    parameter int LOSS_ERR = 8,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         syb,
    input  logic [2:0]         pn,
    input  logic signed [15:0] i,
    input  logic signed [15:0] q,
    input  logic               den,
    input  logic               clr,
`ifdef ERR_INJECT_EN
    input  logic               inj,
`endif
    output logic               lock,
    output logic               busy,
    output logic               err_pulse,
    output logic               overrun,
    output logic [CNT_W-1:0]   bit_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int c_MR_W = $clog2(LOCK_CNT + 1);
    localparam int c_WE_W = $clog2(LOSS_ERR + 1);

    localparam logic [0:0] S_SEARCH = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    // 4-level slicer thresholds (outer pair; the middle one is zero)
    localparam logic signed [15:0] c_T4_LO = -16'sd21845;
    localparam logic signed [15:0] c_T4_HI =  16'sd21845;
    // 8-level slicer thresholds, symmetric around zero
    localparam logic signed [15:0] c_T8_N3 = -16'sd28086;
    localparam logic signed [15:0] c_T8_N2 = -16'sd18724;
    localparam logic signed [15:0] c_T8_N1 = -16'sd9362;
    localparam logic signed [15:0] c_T8_P1 =  16'sd9362;
    localparam logic signed [15:0] c_T8_P2 =  16'sd18724;
    localparam logic signed [15:0] c_T8_P3 =  16'sd28086;

    // Code = number of thresholds the sample is at or above.
    function automatic logic [1:0] f_slice4(input logic signed [15:0] x);
        logic [1:0] c;
        c = 2'd0;
        if (x >= c_T4_LO) c = c + 2'd1;
        if (x >= 16'sd0)  c = c + 2'd1;
        if (x >= c_T4_HI) c = c + 2'd1;
        return c;
    endfunction

    function automatic logic [2:0] f_slice8(input logic signed [15:0] x);
        logic [2:0] c;
        c = 3'd0;
        if (x >= c_T8_N3) c = c + 3'd1;
        if (x >= c_T8_N2) c = c + 3'd1;
        if (x >= c_T8_N1) c = c + 3'd1;
        if (x >= 16'sd0)  c = c + 3'd1;
        if (x >= c_T8_P1) c = c + 3'd1;
        if (x >= c_T8_P2) c = c + 3'd1;
        if (x >= c_T8_P3) c = c + 3'd1;
        return c;
    endfunction

    // Registers
    logic [0:0]        r_state;
    logic [1:0]        r_syb;
    logic [2:0]        r_pn;
    logic [5:0]        r_sh;
    logic [2:0]        r_left;
    logic [14:0]       r_hist;
    logic [3:0]        r_fill;
    logic [c_MR_W-1:0] r_run;
    logic [5:0]        r_win;
    logic [c_WE_W-1:0] r_werr;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_err_pulse;
    logic              r_overrun;

    // Combinational
    logic [0:0]        w_state_nxt;
    logic [1:0]        w_i4, w_q4;
    logic [2:0]        w_i8, w_q8;
    logic [5:0]        w_ld_bits;
    logic [2:0]        w_ld_n;
    logic              w_busy;
    logic              w_last;
    logic              w_mode_chg;
    logic              w_accept;
    logic              w_drop;
    logic              w_cmp;
    logic              w_rx;
    logic [3:0]        w_len;
    logic              w_pred;
    logic              w_filled;
    logic              w_match;
    logic              w_locked;
    logic              w_go_lock;
    logic [c_WE_W:0]   w_werr_nxt;
    logic              w_lose;
    logic              w_cnt_en;

    assign w_i4 = f_slice4(i);
    assign w_q4 = f_slice4(q);
    assign w_i8 = f_slice8(i);
    assign w_q8 = f_slice8(q);

    // Serial load word, MSB is the first bit to be compared
    always_comb begin
        w_ld_bits = 6'd0;
        w_ld_n    = 3'd0;
        case (syb)
            2'd0: begin
                w_ld_bits = {~i[15], 5'd0};
                w_ld_n    = 3'd1;
            end
            2'd1: begin
                w_ld_bits = {~q[15], ~i[15], 4'd0};
                w_ld_n    = 3'd2;
            end
            2'd2: begin
                w_ld_bits = {w_q4, w_i4, 2'd0};
                w_ld_n    = 3'd4;
            end
            default: begin
                w_ld_bits = {w_q8, w_i8};
                w_ld_n    = 3'd6;
            end
        endcase
    end

    assign w_busy     = (r_left != 3'd0);
    assign w_last     = (r_left == 3'd1);
    assign w_mode_chg = (syb != r_syb) || (pn != r_pn);
    // A mode change flushes the serializer, so a sample in that cycle always fits
    assign w_accept   = den && (!w_busy || w_last || w_mode_chg);
    assign w_drop     = den && !w_accept;
    assign w_cmp      = w_busy && !w_mode_chg;

`ifdef ERR_INJECT_EN
    logic r_inj_arm;

    // Arm on an inj pulse, disarm once a compared bit has been inverted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_arm <= 1'b0;
        end else begin
            r_inj_arm <= (r_inj_arm && !w_cmp) || inj;
        end
    end

    assign w_rx = r_sh[5] ^ r_inj_arm;
`else
    assign w_rx = r_sh[5];
`endif

    // Reference length and feedback prediction for the selected PRBS
    always_comb begin
        w_len  = 4'd3;
        w_pred = ~(r_hist[2] ^ r_hist[1]);
        case (r_pn)
            3'd1: begin w_len = 4'd4;  w_pred = ~(r_hist[3]  ^ r_hist[2]);  end
            3'd2: begin w_len = 4'd7;  w_pred = ~(r_hist[6]  ^ r_hist[5]);  end
            3'd3: begin w_len = 4'd9;  w_pred = ~(r_hist[8]  ^ r_hist[4]);  end
            3'd4: begin w_len = 4'd10; w_pred = ~(r_hist[9]  ^ r_hist[6]);  end
            3'd5: begin w_len = 4'd15; w_pred = ~(r_hist[14] ^ r_hist[13]); end
            default: ;
        endcase
    end

    assign w_locked   = (r_state == S_LOCKED);
    assign w_filled   = (r_fill == w_len);
    assign w_match    = (w_rx == w_pred);
    assign w_go_lock  = !w_locked && w_cmp && w_filled && w_match &&
                        (r_run == c_MR_W'(LOCK_CNT - 1));
    assign w_werr_nxt = {1'b0, r_werr} + {{c_WE_W{1'b0}}, ~w_match};
    assign w_lose     = w_locked && w_cmp &&
                        (w_werr_nxt >= (c_WE_W + 1)'(LOSS_ERR));
    assign w_cnt_en   = w_locked && w_cmp;

    // Mode registers used to detect a change of syb or pn
    always_ff @(posedge clk) begin
        if (rst) begin
            r_syb <= 2'd0;
            r_pn  <= 3'd0;
        end else begin
            r_syb <= syb;
            r_pn  <= pn;
        end
    end

    // Serializer: load on accepted sample, otherwise shift one bit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= 6'd0;
            r_left <= 3'd0;
        end else if (w_accept) begin
            r_sh   <= w_ld_bits;
            r_left <= w_ld_n;
        end else if (w_mode_chg) begin
            r_left <= 3'd0;
        end else if (w_busy) begin
            r_sh   <= {r_sh[4:0], 1'b0};
            r_left <= r_left - 3'd1;
        end
    end

    // Reference history: received bits while searching, predictions once locked
    always_ff @(posedge clk) begin
        if (rst || w_mode_chg || w_lose) begin
            r_hist <= 15'd0;
        end else if (w_cmp) begin
            r_hist <= {r_hist[13:0], (w_locked ? w_pred : w_rx)};
        end
    end

    // Fill count and consecutive-match run, only meaningful while searching
    always_ff @(posedge clk) begin
        if (rst || w_mode_chg || w_locked || w_go_lock) begin
            r_fill <= 4'd0;
            r_run  <= '0;
        end else if (w_cmp) begin
            if (!w_filled) begin
                r_fill <= r_fill + 4'd1;
            end else if (w_match) begin
                r_run <= r_run + c_MR_W'(1);
            end else begin
                r_run <= '0;
            end
        end
    end

    // 64-bit loss window and its error count, only running while locked
    always_ff @(posedge clk) begin
        if (rst || w_mode_chg || !w_locked || w_lose) begin
            r_win  <= 6'd0;
            r_werr <= '0;
        end else if (w_cmp) begin
            r_win  <= r_win + 6'd1;
            r_werr <= (r_win == 6'd63) ? '0 : w_werr_nxt[c_WE_W-1:0];
        end
    end

    // Saturating bit/error counters; clear has priority over counting
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_cnt_en) begin
            if (r_bit_cnt != {CNT_W{1'b1}}) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (!w_match && (r_err_cnt != {CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    // Error pulse and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_err_pulse <= w_cnt_en && !w_match;
            if (clr) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: lock on a full match run, drop on window loss or mode change
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SEARCH: if (w_go_lock) w_state_nxt = S_LOCKED;
            S_LOCKED: if (w_lose)    w_state_nxt = S_SEARCH;
            default:  w_state_nxt = S_SEARCH;
        endcase
        if (w_mode_chg) w_state_nxt = S_SEARCH;
    end

    // FSM outputs
    always_comb begin
        lock = (r_state == S_LOCKED);
    end

    assign busy      = w_busy;
    assign err_pulse = r_err_pulse;
    assign overrun   = r_overrun;
    assign bit_cnt   = r_bit_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
